// File: rtl/shift_add_mult_if.sv
// rtl/shift_add_mult_if.sv - request/result bundle for the shift-add multiplier
//
// Purpose: groups the operand request and result signals of shift_add_mult.
// Signals:
//   start      request, sampled only while busy=0
//   is_signed  1 = two's complement operands/product, 0 = unsigned
//   mlier      multiplier, WIDTH bits
//   mcand      multiplicand, WIDTH bits
//   busy       operation in progress
//   valid      one-cycle pulse, prodt newly updated
//   prodt      product, 2*WIDTH bits, held until next result or reset
// Modports: master drives the request, slave is the multiplier.
interface shift_add_mult_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     mlier;
  logic [WIDTH-1:0]     mcand;
  logic                 busy;
  logic                 valid;
  logic [2*WIDTH-1:0]   prodt;

  modport master (
    output start, is_signed, mlier, mcand,
    input  busy, valid, prodt
  );

  modport slave (
    input  start, is_signed, mlier, mcand,
    output busy, valid, prodt
  );
endinterface

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-add multiplier, one multiplier bit per clock
//
// Purpose: WIDTH x WIDTH -> 2*WIDTH multiply with runtime signed/unsigned mode.
// Operands are reduced to magnitudes, multiplied unsigned over WIDTH cycles,
// then the sign is applied in a final cycle, so the most-negative operand is exact.
// Ports:
//   i_clock  rising-edge clock
//   i_reset  synchronous active-high reset
//   bus      shift_add_mult_if.slave (start/is_signed/mlier/mcand in,
//            busy/valid/prodt out)
module shift_add_mult #(
  parameter int WIDTH = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  shift_add_mult_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_mlier;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic                 r_valid;
  logic [2*WIDTH-1:0]   r_prodt;

  logic [WIDTH-1:0]     w_mlier_mag;
  logic [WIDTH-1:0]     w_mcand_mag;
  logic                 w_neg;

  // Two's complement negate wraps modulo 2^WIDTH; read back unsigned,
  // -2^(WIDTH-1) becomes 2^(WIDTH-1), which is its true magnitude.
  assign w_mlier_mag = (bus.is_signed && bus.mlier[WIDTH-1]) ? (~bus.mlier + ONE_W) : bus.mlier;
  assign w_mcand_mag = (bus.is_signed && bus.mcand[WIDTH-1]) ? (~bus.mcand + ONE_W) : bus.mcand;
  assign w_neg       = bus.is_signed & (bus.mlier[WIDTH-1] ^ bus.mcand[WIDTH-1]);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_mlier <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_valid <= 1'b0;
      r_prodt <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mlier <= w_mlier_mag;
            r_mcand <= {{WIDTH{1'b0}}, w_mcand_mag};
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_mlier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand <= r_mcand << 1;
          r_mlier <= r_mlier >> 1;
          r_cnt   <= r_cnt - CW'(1);
          // Counter still holds 1 during the final iteration.
          if (r_cnt == CW'(1)) begin
            r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          r_prodt <= r_neg ? (~r_acc + ONE_2W) : r_acc;
          r_valid <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = (r_state != S_IDLE);
  assign bus.valid = r_valid;
  assign bus.prodt = r_prodt;

endmodule
